mc_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/mc_alu_shifter.sv | 75 +++++++
 rtl/mc_alu.sv | 157 +++++++++++++++
 tb/tb_mc_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU and the ALU control unit.
//   - ALUOperation codes (the control unit drives these onto alu_op)
//   - FSM state type used by mc_alu
//   - is_shift_op(): true for the two iterative shift codes
// Ports: none (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/mc_alu_shifter.sv
// ---------------------------------------------------------------------------
// mc_alu_shifter
// Shift datapath of mc_alu. Two build variants selected by the macro
// MC_ALU_BARREL_SHIFT_EN:
//   undefined : iterative shifter. Holds the accumulator, the remaining-count
//               register and the latched direction; moves one bit per step.
//   defined   : purely combinational barrel shifter of src by amount; no
//               registers are built and the clock/reset/load/step are unused.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture src/amount/dir into acc/cnt/direction
//   step       : shift acc one bit and decrement cnt
//   dir        : 0 = left (sll), 1 = right logical (srl)
//   src        : value to be shifted (operand b)
//   amount     : shift distance (shamt)
//   shifted    : iterative - acc moved by one bit (value after this step)
//                barrel    - src shifted by amount
//   last       : iterative - this step is the final one (cnt == 1)
//                barrel    - always 0
// ---------------------------------------------------------------------------
module mc_alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             dir,
  input  logic [WIDTH-1:0] src,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] shifted,
  output logic             last
);

`ifdef MC_ALU_BARREL_SHIFT_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, load, step};

  assign shifted = dir ? (src >> amount) : (src << amount);
  assign last    = 1'b0;

`else

  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             dir_q;

  // Operands are captured only on load, so later changes on src/amount/dir
  // cannot disturb a shift that is already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      acc   <= src;
      cnt   <= amount;
      dir_q <= dir;
    end else if (step) begin
      acc   <= shifted;
      cnt   <= cnt - SHW'(1);
    end
  end

  assign shifted = dir_q ? (acc >> 1) : (acc << 1);

  // The step taken while cnt is 1 brings it to zero, so its shifted value
  // is already the final answer and can be registered as the result.
  assign last = (cnt == SHW'(1));

`endif

endmodule

// File: rtl/mc_alu.sv
// ---------------------------------------------------------------------------
// mc_alu
// Multi-cycle integer ALU. add/sub/and/or/slt and the undefined code finish
// one cycle after acceptance; sll/srl with a non-zero shamt run one bit per
// cycle while busy is high. result/zero are registered and only change on
// the cycle done pulses.
// Build option: MC_ALU_BARREL_SHIFT_EN - when defined shifts use a barrel
// shifter, finish like arithmetic ops, and busy is tied low.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low reset
//   start   in  1      request strobe, accepted only while busy is low
//   alu_op  in  3      ALUOperation code (alu_pkg constants)
//   a       in  WIDTH  operand A
//   b       in  WIDTH  operand B, also the shift source
//   shamt   in  SHW    shift amount
//   busy    out 1      iterative shift in progress
//   done    out 1      one-cycle pulse, result/zero valid
//   result  out WIDTH  registered result, held until the next done
//   zero    out 1      registered (result == 0)
// ---------------------------------------------------------------------------
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic             load;
  logic             step;
  logic             capture;
  logic             shift_last;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] next_result;

  mc_alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .dir     (alu_op == ALU_SRL),
    .src     (b),
    .amount  (shamt),
    .shifted (shifted),
    .last    (shift_last)
  );

  // Single-cycle result. In the iterative build this path only sees shifts
  // with shamt = 0, whose answer is simply b.
  always_comb begin
    op_result = '0;
    case (alu_op)
      ALU_ADD: op_result = a + b;
      ALU_SUB: op_result = a - b;
      ALU_AND: op_result = a & b;
      ALU_OR:  op_result = a | b;
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef MC_ALU_BARREL_SHIFT_EN
      ALU_SLL, ALU_SRL: op_result = shifted;
`else
      ALU_SLL, ALU_SRL: op_result = b;
`endif
      default: op_result = '0;
    endcase
  end

`ifdef MC_ALU_BARREL_SHIFT_EN

  logic unused_last;
  assign unused_last = shift_last;

  assign load        = 1'b0;
  assign step        = 1'b0;
  assign busy        = 1'b0;
  assign capture     = start;
  assign next_result = op_result;

`else

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // In IDLE every accepted op either finishes now or starts the shifter.
  // In SHIFT start is ignored; the final step's value goes straight to result.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    step        = 1'b0;
    capture     = 1'b0;
    next_result = op_result;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift_op(alu_op) && (shamt != '0)) begin
            load       = 1'b1;
            next_state = SHIFT;
          end else begin
            capture = 1'b1;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (shift_last) begin
          capture     = 1'b1;
          next_result = shifted;
          next_state  = IDLE;
        end
      end
    endcase
  end

  assign busy = (state == SHIFT);

`endif

  // done is a registered copy of capture, so a single request can never
  // produce two consecutive done cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      done <= capture;
      if (capture) begin
        result <= next_result;
        zero   <= (next_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// ---------------------------------------------------------------------------
// tb_mc_alu
// Self-checking bench for mc_alu: directed corner cases followed by random
// transactions compared against a behavioural model of the ALU.
// ---------------------------------------------------------------------------
module tb_mc_alu;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    alu_op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [4:0]    shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;

  int            checks;
  int            errors;
  logic [W-1:0]  last_res;

  mc_alu #(
    .WIDTH (W),
    .SHW   (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: what the op means, not how the RTL builds it.
  function automatic logic [W-1:0] refResult(input logic [2:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic [4:0] sh);
    case (op)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b100:  return y << sh;
      3'b101:  return y >> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Number of cycles busy should stay high for a request.
  function automatic int refBusyCycles(input logic [2:0] op, input logic [4:0] sh);
`ifdef MC_ALU_BARREL_SHIFT_EN
    return 0;
`else
    if ((op == 3'b100 || op == 3'b101) && sh != 5'd0) return int'(sh);
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one request from a negedge, then checks busy/done every cycle
  // until the expected done cycle, and finally result/zero. With jitter set,
  // start stays high with random operands while busy to prove they are ignored.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [4:0] sh, input bit jitter);
    logic [W-1:0] exp;
    int n;
    exp = refResult(op, x, y, sh);
    n   = refBusyCycles(op, sh);
    start  = 1'b1;
    alu_op = op;
    a      = x;
    b      = y;
    shamt  = sh;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      checkOutput("busy", {31'd0, busy}, {31'd0, (k <= n)});
      checkOutput("done", {31'd0, done}, {31'd0, (k == n + 1)});
      if (jitter && k <= n) begin
        start  = 1'b1;
        alu_op = 3'($urandom_range(0, 7));
        a      = $urandom;
        b      = $urandom;
        shamt  = 5'($urandom_range(0, 31));
      end
    end
    checkOutput("result", result, exp);
    checkOutput("zero", {31'd0, zero}, {31'd0, (exp == '0)});
    last_res = exp;
    start = 1'b0;
  endtask

  task automatic idleCycle();
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle_done", {31'd0, done}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_hold", result, last_res);
  endtask

  initial begin
    int pulses;
    logic [2:0] op;
    logic [4:0] sh;
    checks   = 0;
    errors   = 0;
    last_res = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    alu_op   = 3'b000;
    a        = '0;
    b        = '0;
    shamt    = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back arithmetic: the second start lands in the first done cycle.
    applyStimulus(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    applyStimulus(3'b110, 32'd5, 32'd5, 5'd0, 1'b0);
    idleCycle();

    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    applyStimulus(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 1'b0);

    // Long shift with operands and start churning underneath it.
    applyStimulus(3'b100, 32'h1234_5678, 32'h0000_0001, 5'd31, 1'b1);
    applyStimulus(3'b101, 32'h0, 32'h8000_0000, 5'd0, 1'b0);
    applyStimulus(3'b101, 32'h0, 32'h8000_0000, 5'd7, 1'b1);
    applyStimulus(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b0);
    idleCycle();
    idleCycle();

`ifndef MC_ALU_BARREL_SHIFT_EN
    // Reset during cycle t+5 of a 20-bit shift aborts it silently.
    start  = 1'b1;
    alu_op = 3'b100;
    a      = 32'h0;
    b      = 32'h0000_0001;
    shamt  = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 32'd0);
    last_res = '0;
`endif

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      if (i % 3 == 0) op = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b101;
      sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      applyStimulus(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, sh,
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
